// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan generator: pixel strobe, X/Y counters, syncs, strobes
`ifndef VGA_RES_H
`define VGA_RES_H 640
`endif
`ifndef VGA_RES_V
`define VGA_RES_V 480
`endif
`ifndef VGA_CNTR_BIT_WIDTH
`define VGA_CNTR_BIT_WIDTH 10
`endif

module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = `VGA_RES_H,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = `VGA_RES_V,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  output logic                           pix_en,
  output logic [`VGA_CNTR_BIT_WIDTH-1:0] X,
  output logic [`VGA_CNTR_BIT_WIDTH-1:0] Y,
  output logic                           active,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           line_start,
  output logic                           frame_start
);

  localparam int W       = `VGA_CNTR_BIT_WIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [W-1:0]  H_LAST   = W'(H_TOTAL - 1);
  localparam logic [W-1:0]  V_LAST   = W'(V_TOTAL - 1);
  localparam logic [W-1:0]  H_ACT    = W'(H_ACTIVE);
  localparam logic [W-1:0]  V_ACT    = W'(V_ACTIVE);
  localparam logic [W-1:0]  H_SS     = W'(H_ACTIVE + H_FP);
  localparam logic [W-1:0]  H_SE     = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W-1:0]  V_SS     = W'(V_ACTIVE + V_FP);
  localparam logic [W-1:0]  V_SE     = W'(V_ACTIVE + V_FP + V_SYNC);

  // Refuse geometries the counters cannot represent.
  if ((H_TOTAL - 1) >= (1 << W) || (V_TOTAL - 1) >= (1 << W)) begin : g_bad_width
    $error("vga_scan_gen: frame totals do not fit the counter width");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scan_gen: CLK_DIV must be at least 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          div_last;

  assign div_last = (div_q == DIV_LAST);
  assign pix_en   = run && div_last;

  // Next divider phase, next X/Y, and the region flags of that next X/Y so the
  // registered flags always line up with the registered counters.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (run) begin
      div_d = div_last ? '0 : div_q + 1'b1;
    end
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    active_d = (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d  = ((x_d >= H_SS) && (x_d < H_SE)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((y_d >= V_SS) && (y_d < V_SE)) ? SYNC_POL : ~SYNC_POL;
  end

  // Scan state registers; reset parks the beam at (0,0) with syncs released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b1;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = pix_en && (x_q == '0);
  assign frame_start = line_start && (y_q == '0);

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - scoreboard bench for vga_scan_gen on a reduced 15x8 raster
module tb_vga_scan_gen;

  localparam int HT = 15;
  localparam int VT = 8;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, run_a, pe_a, act_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       rst_b, run_b, pe_b, act_b, hs_b, vs_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_scan_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .pix_en(pe_a), .X(x_a), .Y(y_a),
    .active(act_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_scan_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .pix_en(pe_b), .X(x_b), .Y(y_b),
    .active(act_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  pix_t q_a[$];
  pix_t q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected outputs at the k-th pixel strobe since reset: sync window X 10..12, Y 5..6.
  function automatic pix_t model(input int k, input bit pol);
    pix_t p;
    int x, y;
    x = k % HT;
    y = (k / HT) % VT;
    p.x   = 10'(x);
    p.y   = 10'(y);
    p.act = (x < 8) && (y < 4);
    p.hs  = (x >= 10 && x < 13) ? pol : ~pol;
    p.vs  = (y >= 5 && y < 7) ? pol : ~pol;
    p.ls  = (x == 0);
    p.fs  = (x == 0) && (y == 0);
    return p;
  endfunction

  task automatic push_range(input bit which, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      if (which) q_b.push_back(model(k, 1'b1));
      else       q_a.push_back(model(k, 1'b0));
    end
  endtask

  task automatic wait_drain(input bit which, input int budget);
    int n;
    n = 0;
    while (((which ? q_b.size() : q_a.size()) != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if ((which ? q_b.size() : q_a.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%0d timeout left %0d want 0", which, which ? q_b.size() : q_a.size());
      if (which) q_b.delete();
      else       q_a.delete();
    end
  endtask

  int last_fs_a = -1, lines_a = 0;
  bit per_en_a  = 1'b1;
  // Monitor A: pop one expected pixel per strobe, track frame period and line count.
  always @(negedge clk) begin
    if (rst_a) begin
      last_fs_a = -1;
      lines_a   = 0;
    end else if (pe_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_a unexpected strobe X=%0d Y=%0d want none", x_a, y_a);
      end else begin
        chk("pix_a", {x_a, y_a, act_a, hs_a, vs_a, ls_a, fs_a}, q_a.pop_front());
      end
      if (fs_a) begin
        if (last_fs_a >= 0 && per_en_a) begin
          chk("frame_period_a", cyc - last_fs_a, 240);
          chk("lines_per_frame_a", lines_a, 8);
        end
        last_fs_a = cyc;
        lines_a   = 0;
      end
      if (ls_a) lines_a++;
    end else begin
      chk("strobe_idle_a", {ls_a, fs_a}, 2'b00);
    end
  end

  int last_fs_b = -1, lines_b = 0;
  // Monitor B: same scoreboard, plus pix_en must equal run on every clock.
  always @(negedge clk) begin
    chk("pe_eq_run_b", pe_b, run_b);
    if (rst_b) begin
      last_fs_b = -1;
      lines_b   = 0;
    end else if (pe_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_b unexpected strobe X=%0d Y=%0d want none", x_b, y_b);
      end else begin
        chk("pix_b", {x_b, y_b, act_b, hs_b, vs_b, ls_b, fs_b}, q_b.pop_front());
      end
      if (fs_b) begin
        if (last_fs_b >= 0) begin
          chk("frame_period_b", cyc - last_fs_b, 120);
          chk("lines_per_frame_b", lines_b, 8);
        end
        last_fs_b = cyc;
        lines_b   = 0;
      end
      if (ls_b) lines_b++;
    end
  end

  initial begin
    rst_a = 1'b1; run_a = 1'b0;
    rst_b = 1'b1; run_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x_a", x_a, 0);
    chk("rst_y_a", y_a, 0);
    chk("rst_act_a", act_a, 1);
    chk("rst_hs_a", hs_a, 1);
    chk("rst_vs_a", vs_a, 1);
    chk("rst_pe_a", pe_a, 0);
    chk("rst_hs_b", hs_b, 0);
    chk("rst_vs_b", vs_b, 0);

    // Startup timing and two full frames on the divided instance.
    @(posedge clk); #2;
    rst_a = 1'b0; run_a = 1'b1;
    push_range(1'b0, 0, 249);
    @(negedge clk); chk("pe_clk0_a", pe_a, 0);
    @(negedge clk); chk("pe_clk1_a", pe_a, 1); chk("x_clk1_a", x_a, 0);
    @(negedge clk); chk("pe_clk2_a", pe_a, 0); chk("x_edge2_a", x_a, 1);
    wait_drain(1'b0, 1000);

    // Freeze mid-sync at X=10, Y=0 for ten clocks.
    @(negedge clk); #1;
    run_a = 1'b0; per_en_a = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      chk("frz_x_a", x_a, 10);
      chk("frz_y_a", y_a, 0);
      chk("frz_hs_a", hs_a, 0);
      chk("frz_pe_a", pe_a, 0);
    end
    run_a = 1'b1;
    push_range(1'b0, 250, 326);
    @(negedge clk); #1;
    chk("resume_pe_a", pe_a, 1);
    chk("resume_x_a", x_a, 10);
    wait_drain(1'b0, 1000);

    // Beam at X=11, Y=5: both syncs asserted; reset must release them at once.
    chk("pre_rst_x_a", x_a, 11);
    chk("pre_rst_y_a", y_a, 5);
    chk("pre_rst_hs_a", hs_a, 0);
    chk("pre_rst_vs_a", vs_a, 0);
    #1 rst_a = 1'b1;
    #1;
    chk("arst_x_a", x_a, 0);
    chk("arst_y_a", y_a, 0);
    chk("arst_hs_a", hs_a, 1);
    chk("arst_vs_a", vs_a, 1);
    chk("arst_act_a", act_a, 1);
    chk("arst_pe_a", pe_a, 0);
    per_en_a = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst_a = 1'b0;
    push_range(1'b0, 0, 129);
    wait_drain(1'b0, 1000);
    run_a = 1'b0;

    // Undivided instance with active-high syncs.
    @(posedge clk); #2;
    rst_b = 1'b0; run_b = 1'b1;
    push_range(1'b1, 0, 249);
    wait_drain(1'b1, 1000);
    run_b = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("pe_off_b", pe_b, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time %0t want earlier finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
